// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame scheduler: FSM encoding,
// payload width, default timing parameters and a counter-width helper.
package serial_pkg;

  localparam int DATA_W             = 8;
  localparam int GAP_CYCLES_DEF     = 30000;
  localparam int TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Width of a counter that must hold 0..max(a,b) without overflow.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    if (m < 1) m = 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter. pointer names the requester that wins
// a tie; it moves to the other requester whenever a grant is taken.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       pointer
);

  // Combinational winner selection from the current requests and pointer.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = pointer ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Favour the requester that did not just win; only moves on a taken grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pointer <= 1'b0;
    end else if (advance) begin
      pointer <= grant[0];
    end
  end

endmodule

// File: rtl/serial_scheduler.sv
// Serial frame scheduler: arbitrates two position-sample requesters, hands
// one captured sample per frame to a serial transmitter, supervises the
// transmit with a timeout and enforces an idle gap between frames.
module serial_scheduler
  import serial_pkg::*;
#(
  parameter int GAP_CYCLES     = GAP_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] y0,
  input  logic [DATA_W-1:0] z0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] y1,
  input  logic [DATA_W-1:0] z1,
  output logic [1:0]        grant,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_x,
  output logic [DATA_W-1:0] tx_y,
  output logic [DATA_W-1:0] tx_z,
  input  logic              tx_done,
  output logic              gap_active,
  output logic [15:0]       frame_cnt,
  output logic              timeout_err
);

  // One counter serves both the SEND timeout and the GAP length.
  localparam int CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [15:0]      frame_cnt_q;
  logic [1:0]       arb_grant;
  logic             rr_ptr;
  logic             take;
  logic             sel1;

  assign take      = (state == ST_IDLE) && (req != 2'b00);
  assign sel1      = (req == 2'b11) ? rr_ptr : req[1];
  assign frame_cnt = frame_cnt_q;

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .advance (take),
    .grant   (arb_grant),
    .pointer (rr_ptr)
  );

  // Frame FSM with registered outputs, payload latch, counters and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      grant       <= 2'b00;
      tx_start    <= 1'b0;
      tx_x        <= '0;
      tx_y        <= '0;
      tx_z        <= '0;
      gap_active  <= 1'b0;
      frame_cnt_q <= 16'd0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (take) begin
            tx_x     <= sel1 ? x1 : x0;
            tx_y     <= sel1 ? y1 : y0;
            tx_z     <= sel1 ? z1 : z0;
            grant    <= arb_grant;
            tx_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          grant    <= 2'b00;
          tx_start <= 1'b0;
          cnt      <= '0;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          // A completion in the final timeout cycle still counts as success.
          if (tx_done || (cnt == TO_LAST)) begin
            if (tx_done) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
            end else begin
              timeout_err <= 1'b1;
            end
            cnt <= '0;
            if (HAS_GAP) begin
              state      <= ST_GAP;
              gap_active <= 1'b1;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt        <= '0;
            gap_active <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_scheduler.sv
// Directed bench for serial_scheduler: a table of single-frame vectors plus
// hand-written sequences for timeout, reset, stray tx_done and wrap cases.
module tb_serial_scheduler;

  localparam int GAP = 4;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] x0 = 8'h00, y0 = 8'h00, z0 = 8'h00;
  logic [7:0] x1 = 8'h00, y1 = 8'h00, z1 = 8'h00;
  logic       tx_done = 1'b0;

  logic [1:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_x, tx_y, tx_z;
  logic        gap_active;
  logic [15:0] frame_cnt;
  logic        timeout_err;

  logic [1:0]  ng_grant;
  logic        ng_tx_start;
  logic [7:0]  ng_tx_x, ng_tx_y, ng_tx_z;
  logic        ng_gap_active;
  logic [15:0] ng_frame_cnt;
  logic        ng_timeout_err;

  serial_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .x0(x0), .y0(y0), .z0(z0), .x1(x1), .y1(y1), .z1(z1),
    .grant(grant), .tx_start(tx_start),
    .tx_x(tx_x), .tx_y(tx_y), .tx_z(tx_z),
    .tx_done(tx_done), .gap_active(gap_active),
    .frame_cnt(frame_cnt), .timeout_err(timeout_err)
  );

  serial_scheduler #(.GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_ng (
    .clk(clk), .rst_n(rst_n), .req(req),
    .x0(x0), .y0(y0), .z0(z0), .x1(x1), .y1(y1), .z1(z1),
    .grant(ng_grant), .tx_start(ng_tx_start),
    .tx_x(ng_tx_x), .tx_y(ng_tx_y), .tx_z(ng_tx_z),
    .tx_done(tx_done), .gap_active(ng_gap_active),
    .frame_cnt(ng_frame_cnt), .timeout_err(ng_timeout_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int ng_gap_seen = 0;

  always @(negedge clk) begin
    if (ng_gap_active) ng_gap_seen++;
  end

  typedef struct {
    logic [1:0]  req;
    logic [7:0]  x0, y0, z0, x1, y1, z1;
    int          dly;
    logic [1:0]  e_grant;
    logic [7:0]  ex, ey, ez;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Count consecutive negedges with gap_active high, starting at the current one.
  task automatic gap_len(output int g);
    g = 0;
    while (gap_active && g < 200) begin
      g++;
      @(negedge clk);
    end
  endtask

  // One complete frame from IDLE; returns at the first IDLE negedge after the gap.
  task automatic run_vec(input vec_t v, input string tag);
    int g;
    req = v.req;
    x0 = v.x0; y0 = v.y0; z0 = v.z0;
    x1 = v.x1; y1 = v.y1; z1 = v.z1;
    @(negedge clk);
    chk({tag, " grant"}, {30'd0, grant}, {30'd0, v.e_grant});
    chk({tag, " tx_start"}, {31'd0, tx_start}, 32'd1);
    chk({tag, " payload"}, {8'd0, tx_x, tx_y, tx_z}, {8'd0, v.ex, v.ey, v.ez});
    req = 2'b00;
    x0 = ~x0; y0 = ~y0; z0 = ~z0;
    x1 = ~x1; y1 = ~y1; z1 = ~z1;
    @(negedge clk);
    chk({tag, " start_pulse_end"}, {29'd0, grant, tx_start}, 32'd0);
    repeat (v.dly - 1) @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk({tag, " payload_hold"}, {8'd0, tx_x, tx_y, tx_z}, {8'd0, v.ex, v.ey, v.ez});
    chk({tag, " frame_cnt"}, {16'd0, frame_cnt}, {16'd0, v.e_cnt});
    chk({tag, " timeout_err"}, {31'd0, timeout_err}, 32'd0);
    gap_len(g);
    chk({tag, " gap_len"}, g, GAP);
  endtask

  initial begin
    int g, n, t;
    vec_t v;
    logic [1:0] exp_rr [4];

    tbl[0] = '{2'b01, 8'h12, 8'h34, 8'h56, 8'hAA, 8'hBB, 8'hCC, 30, 2'b01, 8'h12, 8'h34, 8'h56, 16'd1};
    tbl[1] = '{2'b11, 8'h01, 8'h02, 8'h03, 8'hA1, 8'hB2, 8'hC3,  5, 2'b10, 8'hA1, 8'hB2, 8'hC3, 16'd2};
    tbl[2] = '{2'b11, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,  3, 2'b01, 8'h11, 8'h22, 8'h33, 16'd3};
    tbl[3] = '{2'b10, 8'h77, 8'h88, 8'h99, 8'hDE, 8'hAD, 8'hBE,  1, 2'b10, 8'hDE, 8'hAD, 8'hBE, 16'd4};
    tbl[4] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFE, 8'hFD,  2, 2'b10, 8'hFF, 8'hFE, 8'hFD, 16'd5};
    tbl[5] = '{2'b11, 8'h5A, 8'hA5, 8'h3C, 8'hC3, 8'h00, 8'hFF, 64, 2'b01, 8'h5A, 8'hA5, 8'h3C, 16'd6};
    tbl[6] = '{2'b01, 8'h80, 8'h7F, 8'h01, 8'h10, 8'h20, 8'h30,  1, 2'b01, 8'h80, 8'h7F, 8'h01, 16'd7};
    tbl[7] = '{2'b11, 8'h01, 8'h01, 8'h01, 8'hFE, 8'hDC, 8'hBA, 10, 2'b10, 8'hFE, 8'hDC, 8'hBA, 16'd8};
    exp_rr[0] = 2'b01; exp_rr[1] = 2'b10; exp_rr[2] = 2'b01; exp_rr[3] = 2'b10;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset outputs", {grant, tx_start, gap_active, timeout_err, frame_cnt, tx_x},
        32'd0);
    chk("reset payload", {16'd0, tx_y, tx_z}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven frames, round-robin state carries across entries
    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    // Stray tx_done in IDLE
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("idle tx_done frame_cnt", {16'd0, frame_cnt}, 32'd8);
    chk("idle tx_done no move", {29'd0, grant, tx_start}, 32'd0);
    chk("idle tx_done no gap", {31'd0, gap_active}, 32'd0);

    // Stray tx_done in GAP
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    tx_done = 1'b1;
    @(negedge clk);
    chk("gap entry frame_cnt", {16'd0, frame_cnt}, 32'd9);
    @(negedge clk);
    tx_done = 1'b0;
    chk("gap tx_done frame_cnt", {16'd0, frame_cnt}, 32'd9);
    gap_len(g);
    chk("gap tx_done remaining gap", g, 3);

    // Timeout with no tx_done
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    n = 0;
    @(negedge clk);
    while (!timeout_err && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("timeout send cycles", n, TO);
    chk("timeout frame_cnt", {16'd0, frame_cnt}, 32'd9);
    chk("timeout enters gap", {31'd0, gap_active}, 32'd1);
    gap_len(g);
    chk("timeout gap_len", g, GAP);
    @(negedge clk);
    chk("timeout back idle", {29'd0, grant, tx_start}, 32'd0);
    chk("timeout sticky", {31'd0, timeout_err}, 32'd1);

    // Reset mid-SEND with frame_cnt = 5
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      v = '{2'b01, 8'h40, 8'h41, 8'h42, 8'h00, 8'h00, 8'h00, 1, 2'b01,
            8'h40, 8'h41, 8'h42, 16'(i + 1)};
      run_vec(v, $sformatf("pre%0d", i));
    end
    req = 2'b01;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset outputs", {grant, tx_start, gap_active, timeout_err, frame_cnt, tx_x},
        32'd0);
    chk("async reset payload", {16'd0, tx_y, tx_z}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    chk("post reset tx_done ignored", {16'd0, frame_cnt}, 32'd0);
    chk("post reset no gap", {31'd0, gap_active}, 32'd0);

    // Continuous req=11 alternates grants, starting with requester 0
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      t = 0;
      @(negedge clk);
      while (grant == 2'b00 && t < 50) begin
        t++;
        @(negedge clk);
      end
      chk($sformatf("rr grant%0d", k), {30'd0, grant}, {30'd0, exp_rr[k]});
      @(negedge clk);
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
    req = 2'b00;
    chk("rr frame_cnt", {16'd0, frame_cnt}, 32'd4);
    gap_len(g);

    // frame_cnt wrap from 0xFFFF
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    v = '{2'b01, 8'h9A, 8'hBC, 8'hDE, 8'h00, 8'h00, 8'h00, 2, 2'b01,
          8'h9A, 8'hBC, 8'hDE, 16'h0000};
    run_vec(v, "wrap");

    // The zero-gap instance never raises gap_active
    chk("no-gap instance gap_active", ng_gap_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_scheduler.md
SERIAL_SCHEDULER -- requirements
Module: serial_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 30000: idle clk cycles enforced after each frame ends.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64: max clk cycles from tx_start to tx_done before abort.
REQ-003 SHALL have port clk  in  1  system clock (25 kHz), all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  in  2  per-requester frame request, level, bit i = requester i.
REQ-006 SHALL have ports x0,y0,z0  in  8 each  requester-0 position sample.
REQ-007 SHALL have ports x1,y1,z1  in  8 each  requester-1 position sample.
REQ-008 SHALL have port grant  out  2  one-hot, one-cycle pulse: requester's sample captured.
REQ-009 SHALL have port tx_start  out  1  one-cycle pulse to serial transmitter: begin frame.
REQ-010 SHALL have ports tx_x,tx_y,tx_z  out  8 each  latched frame payload to transmitter.
REQ-011 SHALL have port tx_done  in  1  one-cycle pulse from transmitter: last bit sent.
REQ-012 SHALL have port gap_active  out  1  high while inter-frame gap counter runs.
REQ-013 SHALL have port frame_cnt  out  16  count of frames completed with tx_done.
REQ-014 SHALL have port timeout_err  out  1  sticky flag: a frame aborted by timeout.

Function
REQ-015 SHALL implement FSM states IDLE, START, SEND, GAP.
REQ-016 IDLE: if req!=0 at posedge, SHALL latch winner's x,y,z into tx_x/tx_y/tx_z and go START; else stay.
REQ-017 START: grant (winner bit) and tx_start SHALL both be 1 for exactly this one cycle; next state SEND unconditionally.
REQ-018 Latency: req sampled in IDLE at edge N -> grant/tx_start high during cycle N+1.
REQ-019 Arbitration SHALL be round-robin: both requesting -> grant the one not granted last; single request -> grant it.
REQ-020 Round-robin pointer SHALL update only on grant; after reset requester 0 wins a tie.
REQ-021 req SHALL be ignored outside IDLE; req dropped before being sampled in IDLE is lost, no error.
REQ-022 tx_x/tx_y/tx_z SHALL hold their value from capture until next capture, unaffected by input changes.
REQ-023 SEND: timeout counter counts cycles in SEND; tx_done -> frame_cnt+1, go GAP.
REQ-024 SEND: counter reaching TIMEOUT_CYCLES without tx_done -> set timeout_err, no frame_cnt increment, go GAP.
REQ-025 tx_done and timeout in same cycle SHALL be treated as tx_done (counted, no error).
REQ-026 tx_done outside SEND SHALL be ignored.
REQ-027 GAP: gap_active=1; counter from 0, exits to IDLE after exactly GAP_CYCLES cycles in GAP.
REQ-028 GAP_CYCLES=0 SHALL skip GAP (SEND -> IDLE directly, gap_active never high).
REQ-029 frame_cnt SHALL wrap 0xFFFF -> 0x0000 silently.
REQ-030 Counter widths SHALL be derived from parameters ($clog2), no overflow for GAP_CYCLES up to 2^20-1.

Reset
REQ-031 rst_n low SHALL immediately force: state IDLE, grant=0, tx_start=0, tx_x/y/z=0, gap_active=0, frame_cnt=0, timeout_err=0, RR pointer to favour requester 0, counters 0.
REQ-032 Reset mid-SEND or mid-GAP SHALL abort without frame_cnt change; first req after release granted per REQ-018.
REQ-033 timeout_err SHALL clear only by reset.

Structure
REQ-034 Shared package serial_pkg SHALL hold FSM state encoding, default GAP_CYCLES/TIMEOUT_CYCLES, payload width 8.
REQ-035 Two-requester round-robin SHALL be a sub-module rr_arbiter_2 (req, advance, grant one-hot, pointer).

Verification
REQ-036 Reset, req=01, x0/y0/z0=0x12/0x34/0x56 -> cycle after sampling grant=01, tx_start=1, tx_x/y/z=0x12/0x34/0x56; tx_done 30 cycles later -> frame_cnt=1, gap_active high GAP_CYCLES cycles.
REQ-037 req=11 continuously, GAP_CYCLES=4 -> grants alternate 01,10,01,10, first is 01.
REQ-038 tx_done never returned, TIMEOUT_CYCLES=64 -> timeout_err=1 after 64 SEND cycles, frame_cnt unchanged, then GAP then IDLE.
REQ-039 tx_done pulsed in IDLE and GAP -> frame_cnt unchanged, no state change.
REQ-040 rst_n low mid-SEND with frame_cnt=5 -> all outputs 0 asynchronously, tx_done after release ignored.
REQ-041 Force frame_cnt path 65535 frames (or preload in sim) -> next tx_done gives 0x0000.
